output_drain: RTL
=================

OUTPUT_DRAIN -- requirements
Module: output_drain

Interface
REQ-001 SHALL have parameter OUTPUT_BUF_NUM, default `OUTPUT_BUF_NUM, number of partial-output buffers to address.
REQ-002 SHALL have parameter BUF_SIZE, default `BUF_SIZE, width in bits of one buffer entry.
REQ-003 SHALL have parameter BEAT_W, default 32, width of one output stream beat; BUF_SIZE SHALL be an integer multiple of BEAT_W (BEATS = BUF_SIZE/BEAT_W).
REQ-004 SHALL have clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have rst_i, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have start_i, input, 1, drain request, sampled only in IDLE.
REQ-007 SHALL have base_sel_i, input, $clog2(OUTPUT_BUF_NUM), first buffer index to drain.
REQ-008 SHALL have cnt_i, input, $clog2(OUTPUT_BUF_NUM)+1, number of buffers to drain.
REQ-009 SHALL have out_sel_o, output, $clog2(OUTPUT_BUF_NUM), buffer read index driven to the output buffer's out_sel_i.
REQ-010 SHALL have out_dat_i, input, BUF_SIZE, combinational read data returned for out_sel_o in the same cycle.
REQ-011 SHALL have m_val_o, output, 1, stream beat valid.
REQ-012 SHALL have m_rdy_i, input, 1, stream beat accept.
REQ-013 SHALL have m_dat_o, output, BEAT_W, stream beat data.
REQ-014 SHALL have m_last_o, output, 1, marks the final beat of the whole drain.
REQ-015 SHALL have busy_o, output, 1, high in every state except IDLE.
REQ-016 SHALL have done_o, output, 1, one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SEND, DONE.
REQ-018 IDLE: on start_i=1 SHALL latch base_sel_i as current index and min(cnt_i, OUTPUT_BUF_NUM) as remaining count; go LOAD if count>0, else DONE.
REQ-019 start_i while not in IDLE SHALL be ignored, with no queuing.
REQ-020 LOAD: SHALL drive out_sel_o = current index, capture out_dat_i into a BUF_SIZE shift register, clear the beat counter, and go SEND next cycle.
REQ-021 SEND: SHALL assert m_val_o with m_dat_o = shift register bits [BEAT_W-1:0], least-significant beat first.
REQ-022 A beat SHALL transfer only on m_val_o & m_rdy_i; on transfer the shift register shifts right by BEAT_W and the beat counter increments.
REQ-023 While m_val_o=1 and m_rdy_i=0, m_dat_o and m_last_o SHALL hold stable.
REQ-024 On transfer of beat BEATS-1: if remaining count > 1, SHALL decrement it, advance the index (modulo OUTPUT_BUF_NUM, wrapping N-1 -> 0) and go LOAD; otherwise SHALL go DONE.
REQ-025 m_last_o SHALL be 1 only during beat BEATS-1 of the final buffer.
REQ-026 DONE: SHALL assert done_o for exactly one cycle, then go IDLE.
REQ-027 Latency: with start_i sampled at edge k, LOAD SHALL occupy cycle k+1, and first m_val_o SHALL occur in cycle k+2; there is one bubble cycle (LOAD) between buffers.
REQ-028 out_sel_o SHALL hold its last value outside LOAD.
REQ-029 m_val_o SHALL be 0 in IDLE, LOAD and DONE.
REQ-030 The block SHALL never write the output buffer; it is read-only.

Reset
REQ-031 rst_i=1 SHALL immediately, without waiting for a clock edge, force state IDLE, m_val_o=0, m_last_o=0, done_o=0, busy_o=0, out_sel_o=0, m_dat_o=0, and clear counters and the shift register.
REQ-032 Reset mid-drain SHALL abandon the drain without a done_o pulse; the next start_i after release SHALL behave as from power-up.

Verification (bench config OUTPUT_BUF_NUM=4, BUF_SIZE=64, BEAT_W=32)
REQ-033 Reset: assert rst_i between clock edges during SEND -> m_val_o, busy_o and out_sel_o read 0 before the next edge.
REQ-034 Basic: buf1=0x11112222_33334444, buf2=0xAAAABBBB_CCCCDDDD, base=1, cnt=2, m_rdy_i=1 -> beats 0x33334444, 0x11112222, (bubble), 0xCCCCDDDD, 0xAAAABBBB; first m_val_o 2 cycles after start; m_last_o on 4th beat only; done_o 1 cycle later.
REQ-035 Wrap: base=3, cnt=3 -> out_sel_o sequence 3,0,1 in the LOAD cycles; 6 beats total.
REQ-036 Backpressure: m_rdy_i=0 for 3 cycles on beat 1 -> m_dat_o unchanged and no beat lost or duplicated.
REQ-037 Bounds: cnt=0 -> done_o in the cycle after start, no m_val_o; cnt=7 -> exactly 4 buffers (8 beats) drained.
REQ-038 start_i pulsed during SEND -> ignored; beat count and done_o timing unchanged.

Source files
------------

// File: rtl/output_drain.sv
// rtl/output_drain.sv - drains a run of partial-output buffers onto a beat stream
// Each buffer is read once into a shift register and emitted LSB beat first.
`ifndef OUTPUT_BUF_NUM
  `define OUTPUT_BUF_NUM 4
`endif
`ifndef BUF_SIZE
  `define BUF_SIZE 64
`endif

module output_drain #(
  parameter int OUTPUT_BUF_NUM = `OUTPUT_BUF_NUM,
  parameter int BUF_SIZE       = `BUF_SIZE,
  parameter int BEAT_W         = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0]   base_sel_i,
  input  logic [$clog2(OUTPUT_BUF_NUM):0]     cnt_i,
  output logic [$clog2(OUTPUT_BUF_NUM)-1:0]   out_sel_o,
  input  logic [BUF_SIZE-1:0]                 out_dat_i,
  output logic                                m_val_o,
  input  logic                                m_rdy_i,
  output logic [BEAT_W-1:0]                   m_dat_o,
  output logic                                m_last_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int SEL_W  = $clog2(OUTPUT_BUF_NUM);
  localparam int CNT_W  = SEL_W + 1;
  localparam int BEATS  = BUF_SIZE / BEAT_W;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t              state_q;
  logic [SEL_W-1:0]    out_sel_q;
  logic [CNT_W-1:0]    rem_q;
  logic [BCNT_W-1:0]   beat_q;
  logic [BUF_SIZE-1:0] shreg_q;

  logic [CNT_W-1:0]    cnt_clip_d;
  logic [SEL_W-1:0]    sel_next_d;
  logic                last_beat_d;

  always_comb begin
    cnt_clip_d  = (cnt_i > CNT_W'(OUTPUT_BUF_NUM)) ? CNT_W'(OUTPUT_BUF_NUM) : cnt_i;
    sel_next_d  = (out_sel_q == SEL_W'(OUTPUT_BUF_NUM - 1)) ? '0 : out_sel_q + 1'b1;
    last_beat_d = (beat_q == BCNT_W'(BEATS - 1));
  end

  // out_sel_q doubles as the current index; it only moves when entering LOAD
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      out_sel_q <= '0;
      rem_q     <= '0;
      beat_q    <= '0;
      shreg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_q <= cnt_clip_d;
            if (cnt_clip_d != '0) begin
              out_sel_q <= base_sel_i;
              state_q   <= LOAD;
            end else begin
              state_q   <= DONE;
            end
          end
        end
        LOAD: begin
          shreg_q <= out_dat_i;
          beat_q  <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (m_rdy_i) begin
            shreg_q <= shreg_q >> BEAT_W;
            beat_q  <= beat_q + 1'b1;
            if (last_beat_d) begin
              if (rem_q > CNT_W'(1)) begin
                rem_q     <= rem_q - 1'b1;
                out_sel_q <= sel_next_d;
                state_q   <= LOAD;
              end else begin
                state_q   <= DONE;
              end
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_sel_o = out_sel_q;
  assign m_val_o   = (state_q == SEND);
  assign m_dat_o   = shreg_q[BEAT_W-1:0];
  assign m_last_o  = (state_q == SEND) && last_beat_d && (rem_q <= CNT_W'(1));
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

endmodule
